// File: rtl/rd_ddr_queue_engine.sv
// rtl/rd_ddr_queue_engine.sv - splits queue read commands into AXI4 read bursts over per-queue DDR rings
module rd_ddr_queue_engine #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int P_DDR_LOCAL_QUEUE = 4,
    parameter int P_QUEUE_NUM = 8,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] P_QUEUE_SIZE = 32'h0008_0000,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] P_BASE_ADDR = 32'h0000_0000,
    parameter int P_BURST_LEN = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_rd_flag,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]      i_rd_queue,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_rd_byte,
    input  logic                              i_rd_byte_valid,
    output logic                              o_rd_byte_ready,
    output logic                              o_rd_queue_finish,
    output logic                              o_rd_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     o_m_axi_araddr,
    output logic [7:0]                        o_m_axi_arlen,
    output logic                              o_m_axi_arvalid,
    input  logic                              i_m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_m_axi_rdata,
    input  logic                              i_m_axi_rvalid,
    input  logic                              i_m_axi_rlast,
    output logic                              o_m_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     o_data,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   o_data_keep,
    output logic                              o_data_valid,
    output logic                              o_data_last,
    output logic                              o_data_flag,
    input  logic                              i_data_ready,
    output logic                              o_rd_ptr_valid,
    output logic [P_DDR_LOCAL_QUEUE-1:0]      o_rd_ptr_queue,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     o_rd_ptr
);

    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int BB  = C_M_AXI_DATA_WIDTH / 8;
    localparam int BSH = $clog2(BB);
    localparam int QIW = (P_QUEUE_NUM > 1) ? $clog2(P_QUEUE_NUM) : 1;
    localparam logic [AW-1:0] BL = AW'(P_BURST_LEN);
    localparam logic [AW-1:0] BB_A = AW'(BB);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_DATA, S_DONE} state_t;

    state_t state, state_n;

    logic [P_DDR_LOCAL_QUEUE-1:0] q_reg;
    logic                         flag_reg;
    logic                         err_reg;
    logic                         zero_reg;
    logic [AW-1:0]                rem;
    logic [BB-1:0]                keep_last;
    logic [AW-1:0]                araddr_reg;
    logic [7:0]                   arlen_reg;
    logic [AW-1:0]                rptr [P_QUEUE_NUM];

    logic [QIW-1:0] q_idx;
    logic [AW-1:0]  cur_rptr;
    logic [AW-1:0]  next_rptr;
    logic [AW-1:0]  space_beats;
    logic [AW-1:0]  burst_a;
    logic [AW-1:0]  burst;
    logic [AW-1:0]  queue_base;
    logic [AW-1:0]  beats_total;
    logic [BB-1:0]  keep_calc;
    logic           r_hs;

    assign q_idx       = q_reg[QIW-1:0];
    assign cur_rptr    = rptr[q_idx];
    assign next_rptr   = (cur_rptr + BB_A == P_QUEUE_SIZE) ? '0 : cur_rptr + BB_A;
    assign space_beats = (P_QUEUE_SIZE - cur_rptr) >> BSH;
    assign burst_a     = (rem < BL) ? rem : BL;
    assign burst       = (space_beats < burst_a) ? space_beats : burst_a;
    assign queue_base  = P_BASE_ADDR + AW'(q_reg) * P_QUEUE_SIZE;
    assign beats_total = (i_rd_byte >> BSH) + {{(AW-1){1'b0}}, |i_rd_byte[BSH-1:0]};
    assign r_hs        = (state == S_DATA) && i_m_axi_rvalid && i_data_ready;

    // Last-beat byte mask: low (bytes mod BB) lanes, or every lane when the count is beat-aligned
    always_comb begin
        keep_calc = '1;
        if (i_rd_byte[BSH-1:0] != '0) begin
            keep_calc = ~({BB{1'b1}} << i_rd_byte[BSH-1:0]);
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n           = state;
        o_rd_byte_ready   = 1'b0;
        o_m_axi_arvalid   = 1'b0;
        o_m_axi_rready    = 1'b0;
        o_data_valid      = 1'b0;
        o_rd_queue_finish = 1'b0;
        o_rd_err          = 1'b0;
        o_rd_ptr_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                o_rd_byte_ready = i_rst;
                if (i_rd_byte_valid && i_rst) begin
                    state_n = S_CALC;
                end
            end
            S_CALC: begin
                state_n = (err_reg || rem == '0) ? S_DONE : S_AR;
            end
            S_AR: begin
                o_m_axi_arvalid = 1'b1;
                if (i_m_axi_arready) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                o_m_axi_rready = i_data_ready;
                o_data_valid   = i_m_axi_rvalid;
                if (r_hs && i_m_axi_rlast) begin
                    state_n = (rem > 1) ? S_CALC : S_DONE;
                end
            end
            S_DONE: begin
                o_rd_queue_finish = 1'b1;
                o_rd_err          = err_reg;
                o_rd_ptr_valid    = !err_reg && !zero_reg;
                state_n           = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Command capture, burst sizing, beat accounting and per-queue read pointers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            q_reg      <= '0;
            flag_reg   <= 1'b0;
            err_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            rem        <= '0;
            keep_last  <= '0;
            araddr_reg <= '0;
            arlen_reg  <= '0;
            for (int i = 0; i < P_QUEUE_NUM; i++) begin
                rptr[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_rd_byte_valid) begin
                        q_reg     <= i_rd_queue;
                        flag_reg  <= i_rd_flag;
                        err_reg   <= int'(i_rd_queue) >= P_QUEUE_NUM;
                        zero_reg  <= i_rd_byte == '0;
                        rem       <= beats_total;
                        keep_last <= keep_calc;
                    end
                end
                S_CALC: begin
                    araddr_reg <= queue_base + cur_rptr;
                    arlen_reg  <= burst[7:0] - 8'd1;
                end
                S_DATA: begin
                    if (r_hs) begin
                        rem         <= rem - 1'b1;
                        rptr[q_idx] <= next_rptr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_m_axi_araddr = o_m_axi_arvalid ? araddr_reg : '0;
    assign o_m_axi_arlen  = o_m_axi_arvalid ? arlen_reg : '0;
    assign o_data         = (state == S_DATA) ? i_m_axi_rdata : '0;
    assign o_data_flag    = (state == S_DATA) ? flag_reg : 1'b0;
    assign o_data_last    = o_data_valid && (rem == 1);
    assign o_data_keep    = (state != S_DATA) ? '0 : ((rem == 1) ? keep_last : '1);
    assign o_rd_ptr_queue = o_rd_ptr_valid ? q_reg : '0;
    assign o_rd_ptr       = o_rd_ptr_valid ? cur_rptr : '0;

endmodule

// File: tb/tb_rd_ddr_queue_engine.sv
// tb/tb_rd_ddr_queue_engine.sv - directed self-checking bench for rd_ddr_queue_engine
module tb_rd_ddr_queue_engine;

    localparam logic [31:0] QS = 32'h0000_0200;

    logic        clk;
    logic        i_rst;
    logic        i_rd_flag;
    logic [3:0]  i_rd_queue;
    logic [31:0] i_rd_byte;
    logic        i_rd_byte_valid;
    logic        o_rd_byte_ready;
    logic        o_rd_queue_finish;
    logic        o_rd_err;
    logic [31:0] o_m_axi_araddr;
    logic [7:0]  o_m_axi_arlen;
    logic        o_m_axi_arvalid;
    logic        i_m_axi_arready;
    logic [63:0] i_m_axi_rdata;
    logic        i_m_axi_rvalid;
    logic        i_m_axi_rlast;
    logic        o_m_axi_rready;
    logic [63:0] o_data;
    logic [7:0]  o_data_keep;
    logic        o_data_valid;
    logic        o_data_last;
    logic        o_data_flag;
    logic        i_data_ready;
    logic        o_rd_ptr_valid;
    logic [3:0]  o_rd_ptr_queue;
    logic [31:0] o_rd_ptr;

    rd_ddr_queue_engine #(
        .P_QUEUE_SIZE(QS)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_rd_flag(i_rd_flag), .i_rd_queue(i_rd_queue),
        .i_rd_byte(i_rd_byte), .i_rd_byte_valid(i_rd_byte_valid), .o_rd_byte_ready(o_rd_byte_ready),
        .o_rd_queue_finish(o_rd_queue_finish), .o_rd_err(o_rd_err),
        .o_m_axi_araddr(o_m_axi_araddr), .o_m_axi_arlen(o_m_axi_arlen), .o_m_axi_arvalid(o_m_axi_arvalid),
        .i_m_axi_arready(i_m_axi_arready), .i_m_axi_rdata(i_m_axi_rdata), .i_m_axi_rvalid(i_m_axi_rvalid),
        .i_m_axi_rlast(i_m_axi_rlast), .o_m_axi_rready(o_m_axi_rready),
        .o_data(o_data), .o_data_keep(o_data_keep), .o_data_valid(o_data_valid), .o_data_last(o_data_last),
        .o_data_flag(o_data_flag), .i_data_ready(i_data_ready),
        .o_rd_ptr_valid(o_rd_ptr_valid), .o_rd_ptr_queue(o_rd_ptr_queue), .o_rd_ptr(o_rd_ptr)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    bit gaps = 0;
    int ar_delay = 0;
    bit abort = 0;

    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int          ar_start_q[$];
    int          ar_hs_q[$];
    logic [63:0] bd_q[$];
    logic [7:0]  bk_q[$];
    bit          bl_q[$];
    bit          bf_q[$];
    int          bc_q[$];
    int          fin_q[$];
    int          err_q[$];
    logic [31:0] ptr_q[$];
    logic [3:0]  ptrq_q[$];
    int          ar_unstable;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time-stamp observed events
    always @(posedge clk) cyc <= cyc + 1;

    // AXI read slave model plus output monitor
    initial begin : slave
        bit          ar_hs, r_hs, ar_hold, s_active;
        logic [31:0] hold_addr, s_addr;
        logic [7:0]  hold_len;
        int          s_left, ar_wait;
        ar_hold = 0; s_active = 0; s_left = 0; ar_wait = 0; s_addr = '0;
        hold_addr = '0; hold_len = '0; ar_unstable = 0;
        i_m_axi_arready = 0; i_m_axi_rvalid = 0; i_m_axi_rlast = 0; i_m_axi_rdata = '0;
        i_data_ready = 1;
        forever begin
            @(negedge clk);
            ar_hs = o_m_axi_arvalid && i_m_axi_arready;
            r_hs  = i_m_axi_rvalid && o_m_axi_rready;
            if (o_m_axi_arvalid) begin
                if (ar_hold && (o_m_axi_araddr !== hold_addr || o_m_axi_arlen !== hold_len))
                    ar_unstable++;
                if (!ar_hold) ar_start_q.push_back(cyc);
                ar_hold = 1; hold_addr = o_m_axi_araddr; hold_len = o_m_axi_arlen;
            end else begin
                ar_hold = 0;
            end
            if (ar_hs) begin
                ar_addr_q.push_back(o_m_axi_araddr);
                ar_len_q.push_back(o_m_axi_arlen);
                ar_hs_q.push_back(cyc);
                ar_hold = 0;
            end
            if (o_data_valid && i_data_ready) begin
                bd_q.push_back(o_data); bk_q.push_back(o_data_keep);
                bl_q.push_back(o_data_last); bf_q.push_back(o_data_flag); bc_q.push_back(cyc);
            end
            if (o_rd_queue_finish) fin_q.push_back(cyc);
            if (o_rd_err) err_q.push_back(cyc);
            if (o_rd_ptr_valid) begin
                ptr_q.push_back(o_rd_ptr); ptrq_q.push_back(o_rd_ptr_queue);
            end
            @(posedge clk);
            #1;
            if (abort) begin
                s_active = 0; s_left = 0; ar_wait = 0;
                i_m_axi_rvalid = 0; i_m_axi_rlast = 0; i_m_axi_arready = 0;
            end else begin
                if (r_hs) begin
                    s_left--; s_addr += 32'd8;
                    if (s_left == 0) s_active = 0;
                end
                if (ar_hs) begin
                    s_active = 1; s_addr = hold_addr; s_left = int'(hold_len) + 1; ar_wait = 0;
                end
                if (o_m_axi_arvalid && !s_active) begin
                    if (ar_wait >= ar_delay) i_m_axi_arready = 1;
                    else begin i_m_axi_arready = 0; ar_wait++; end
                end else begin
                    i_m_axi_arready = 0;
                end
                if (s_active && s_left > 0) begin
                    if (!(i_m_axi_rvalid && !r_hs)) begin
                        i_m_axi_rvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                        i_m_axi_rdata  = pat(s_addr);
                        i_m_axi_rlast  = (s_left == 1);
                    end
                end else begin
                    i_m_axi_rvalid = 0; i_m_axi_rlast = 0;
                end
            end
            i_data_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic clear_mon();
        ar_addr_q.delete(); ar_len_q.delete(); ar_start_q.delete(); ar_hs_q.delete();
        bd_q.delete(); bk_q.delete(); bl_q.delete(); bf_q.delete(); bc_q.delete();
        fin_q.delete(); err_q.delete(); ptr_q.delete(); ptrq_q.delete();
        ar_unstable = 0;
    endtask

    task automatic send_cmd(input logic [3:0] q, input logic [31:0] bytes, input logic flag, output int t);
        @(posedge clk); #1;
        i_rd_queue = q; i_rd_byte = bytes; i_rd_flag = flag; i_rd_byte_valid = 1;
        t = -1;
        for (int i = 0; i < 50 && t < 0; i++) begin
            @(negedge clk);
            if (o_rd_byte_ready) t = cyc;
        end
        @(posedge clk); #1;
        i_rd_byte_valid = 0;
        if (t < 0) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept: ready never seen for queue %0d bytes %0d", q, bytes);
        end
    endtask

    task automatic do_cmd(input logic [3:0] q, input logic [31:0] bytes, input logic flag, output int t);
        int k;
        clear_mon();
        send_cmd(q, bytes, flag, t);
        k = 0;
        while (fin_q.size() == 0 && k < 3000) begin
            @(posedge clk); #2; k++;
        end
        if (fin_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL finish_timeout: no finish for queue %0d bytes %0d", q, bytes);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        i_rst = 0; i_rd_byte_valid = 0; i_rd_queue = '0; i_rd_byte = '0; i_rd_flag = 0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({o_rd_byte_ready, o_rd_queue_finish, o_rd_err, o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arvalid,
             o_m_axi_rready, o_data, o_data_keep, o_data_valid, o_data_last, o_data_flag,
             o_rd_ptr_valid, o_rd_ptr_queue, o_rd_ptr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero (ready=%b arvalid=%b keep=%h)",
                     o_rd_byte_ready, o_m_axi_arvalid, o_data_keep);
        end
        @(posedge clk); #1;
        i_rst = 1;
        #1;
        n_checks++;
        if (o_rd_byte_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_rd_byte_ready);
        end
    endtask

    task automatic test_multi_burst();
        int t;
        logic [31:0] exp_addr [3];
        logic [7:0]  exp_len [3];
        exp_addr = '{32'h400, 32'h480, 32'h500};
        exp_len  = '{8'd15, 8'd15, 8'd5};
        gaps = 0; ar_delay = 0;
        do_cmd(4'd2, 32'd300, 1'b1, t);
        n_checks++;
        if (ar_addr_q.size() !== 3) begin
            n_fail++; $display("FAIL mb_ar_count: got %0d want 3", ar_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (ar_addr_q[i] !== exp_addr[i] || ar_len_q[i] !== exp_len[i]) begin
                    n_fail++;
                    $display("FAIL mb_ar%0d: got %h/%0d want %h/%0d", i, ar_addr_q[i], ar_len_q[i], exp_addr[i], exp_len[i]);
                end
            end
            n_checks++;
            if (ar_start_q[0] !== t + 2) begin
                n_fail++; $display("FAIL mb_ar_latency: got cycle %0d want %0d", ar_start_q[0], t + 2);
            end
        end
        n_checks++;
        if (bd_q.size() !== 38) begin
            n_fail++; $display("FAIL mb_beat_count: got %0d want 38", bd_q.size());
        end else begin
            for (int i = 0; i < 38; i++) begin
                n_checks++;
                if (bd_q[i] !== pat(32'h400 + 32'(8 * i)) || bf_q[i] !== 1'b1 ||
                    bl_q[i] !== (i == 37) || bk_q[i] !== ((i == 37) ? 8'h0F : 8'hFF)) begin
                    n_fail++;
                    $display("FAIL mb_beat%0d: data %h keep %h last %b flag %b", i, bd_q[i], bk_q[i], bl_q[i], bf_q[i]);
                end
            end
            n_checks++;
            if (ar_start_q.size() < 2 || ar_start_q[1] !== bc_q[15] + 2) begin
                n_fail++; $display("FAIL mb_second_ar: got %0d want %0d", (ar_start_q.size() < 2) ? -1 : ar_start_q[1], bc_q[15] + 2);
            end
            n_checks++;
            if (fin_q.size() !== 1 || fin_q[0] !== bc_q[37] + 1) begin
                n_fail++; $display("FAIL mb_finish: count %0d want finish at %0d", fin_q.size(), bc_q[37] + 1);
            end
        end
        n_checks++;
        if (ptr_q.size() !== 1 || ptr_q[0] !== 32'h130 || ptrq_q[0] !== 4'd2) begin
            n_fail++; $display("FAIL mb_rd_ptr: count %0d value %h want 1 x 130 queue 2", ptr_q.size(), (ptr_q.size() > 0) ? ptr_q[0] : 32'hX);
        end
        n_checks++;
        if (err_q.size() !== 0) begin
            n_fail++; $display("FAIL mb_err: got %0d err pulses want 0", err_q.size());
        end
    endtask

    task automatic test_wrap();
        int t;
        do_cmd(4'd0, 32'h1C0, 1'b0, t);
        n_checks++;
        if (ptr_q.size() !== 1 || ptr_q[0] !== 32'h1C0) begin
            n_fail++; $display("FAIL wrap_pre_ptr: got %h want 1c0", (ptr_q.size() > 0) ? ptr_q[0] : 32'hX);
        end
        do_cmd(4'd0, 32'd128, 1'b0, t);
        n_checks++;
        if (ar_addr_q.size() !== 2 || ar_addr_q[0] !== 32'h1C0 || ar_len_q[0] !== 8'd7 ||
            ar_addr_q[1] !== 32'h0 || ar_len_q[1] !== 8'd7) begin
            n_fail++; $display("FAIL wrap_bursts: count %0d first %h want 1c0/7 then 0/7", ar_addr_q.size(),
                               (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hX);
        end
        n_checks++;
        if (bd_q.size() !== 16) begin
            n_fail++; $display("FAIL wrap_beats: got %0d want 16", bd_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (bd_q[i] !== pat((32'h1C0 + 32'(8 * i)) % QS) || bf_q[i] !== 1'b0) begin
                    n_fail++; $display("FAIL wrap_beat%0d: got %h want %h", i, bd_q[i], pat((32'h1C0 + 32'(8 * i)) % QS));
                end
            end
        end
        n_checks++;
        if (ptr_q.size() !== 1 || ptr_q[0] !== 32'h40) begin
            n_fail++; $display("FAIL wrap_ptr: got %h want 40", (ptr_q.size() > 0) ? ptr_q[0] : 32'hX);
        end
    endtask

    task automatic test_zero_bytes();
        int t;
        do_cmd(4'd1, 32'd0, 1'b0, t);
        n_checks++;
        if (fin_q.size() !== 1 || fin_q[0] !== t + 2) begin
            n_fail++; $display("FAIL zero_finish: got %0d at %0d want 1 at %0d", fin_q.size(), (fin_q.size() > 0) ? fin_q[0] : -1, t + 2);
        end
        n_checks++;
        if (ar_start_q.size() !== 0 || ptr_q.size() !== 0 || err_q.size() !== 0 || bd_q.size() !== 0) begin
            n_fail++; $display("FAIL zero_side_effects: ar %0d ptr %0d err %0d beats %0d want all 0",
                               ar_start_q.size(), ptr_q.size(), err_q.size(), bd_q.size());
        end
    endtask

    task automatic test_bad_queue();
        int t;
        do_cmd(4'd9, 32'd64, 1'b0, t);
        n_checks++;
        if (err_q.size() !== 1 || err_q[0] !== t + 2 || fin_q.size() !== 1 || fin_q[0] !== t + 2) begin
            n_fail++; $display("FAIL err_pulse: err %0d fin %0d want both once at %0d", err_q.size(), fin_q.size(), t + 2);
        end
        n_checks++;
        if (ar_start_q.size() !== 0 || ptr_q.size() !== 0) begin
            n_fail++; $display("FAIL err_side_effects: ar %0d ptr %0d want 0", ar_start_q.size(), ptr_q.size());
        end
        do_cmd(4'd2, 32'd8, 1'b0, t);
        n_checks++;
        if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== 32'h530 || ptr_q.size() !== 1 || ptr_q[0] !== 32'h138) begin
            n_fail++; $display("FAIL err_q2_kept: addr %h ptr %h want 530/138", (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hX,
                               (ptr_q.size() > 0) ? ptr_q[0] : 32'hX);
        end
        do_cmd(4'd0, 32'd8, 1'b0, t);
        n_checks++;
        if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== 32'h40 || ptr_q.size() !== 1 || ptr_q[0] !== 32'h48) begin
            n_fail++; $display("FAIL err_q0_kept: addr %h ptr %h want 40/48", (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hX,
                               (ptr_q.size() > 0) ? ptr_q[0] : 32'hX);
        end
    endtask

    task automatic test_backpressure();
        int t;
        logic [31:0] exp_addr [8];
        exp_addr = '{32'h600, 32'h680, 32'h700, 32'h780, 32'h600, 32'h680, 32'h700, 32'h780};
        gaps = 1; ar_delay = 5;
        do_cmd(4'd3, 32'd1000, 1'b1, t);
        gaps = 0; ar_delay = 0;
        n_checks++;
        if (ar_addr_q.size() !== 8) begin
            n_fail++; $display("FAIL bp_ar_count: got %0d want 8", ar_addr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (ar_addr_q[i] !== exp_addr[i] || ar_len_q[i] !== ((i == 7) ? 8'd12 : 8'd15) ||
                    ar_hs_q[i] - ar_start_q[i] !== 5) begin
                    n_fail++; $display("FAIL bp_ar%0d: got %h/%0d held %0d want %h/%0d held 5", i, ar_addr_q[i], ar_len_q[i],
                                       ar_hs_q[i] - ar_start_q[i], exp_addr[i], (i == 7) ? 12 : 15);
                end
            end
        end
        n_checks++;
        if (ar_unstable !== 0) begin
            n_fail++; $display("FAIL bp_ar_stable: got %0d changes while stalled want 0", ar_unstable);
        end
        n_checks++;
        if (bd_q.size() !== 125) begin
            n_fail++; $display("FAIL bp_beat_count: got %0d want 125", bd_q.size());
        end else begin
            for (int i = 0; i < 125; i++) begin
                n_checks++;
                if (bd_q[i] !== pat(32'h600 + (32'(8 * i) % QS)) || bl_q[i] !== (i == 124) || bk_q[i] !== 8'hFF) begin
                    n_fail++; $display("FAIL bp_beat%0d: data %h keep %h last %b", i, bd_q[i], bk_q[i], bl_q[i]);
                end
            end
        end
        n_checks++;
        if (ptr_q.size() !== 1 || ptr_q[0] !== 32'h1E8 || ptrq_q[0] !== 4'd3) begin
            n_fail++; $display("FAIL bp_ptr: got %h want 1e8", (ptr_q.size() > 0) ? ptr_q[0] : 32'hX);
        end
    endtask

    task automatic test_reset_mid_data();
        int t, k;
        clear_mon();
        send_cmd(4'd1, 32'd200, 1'b0, t);
        k = 0;
        while (bd_q.size() < 3 && k < 200) begin
            @(posedge clk); #2; k++;
        end
        n_checks++;
        if (bd_q.size() < 3) begin
            n_fail++; $display("FAIL rst_mid_progress: got %0d beats want >= 3", bd_q.size());
        end
        i_rst = 0; abort = 1;
        @(posedge clk); #2;
        n_checks++;
        if ({o_rd_byte_ready, o_rd_queue_finish, o_rd_err, o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arvalid,
             o_m_axi_rready, o_data, o_data_keep, o_data_valid, o_data_last, o_data_flag,
             o_rd_ptr_valid, o_rd_ptr_queue, o_rd_ptr} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: some output nonzero (valid=%b keep=%h rready=%b)",
                               o_data_valid, o_data_keep, o_m_axi_rready);
        end
        @(posedge clk); #1;
        i_rst = 1; abort = 0;
        #1;
        n_checks++;
        if (o_rd_byte_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_ready: got %b want 1", o_rd_byte_ready);
        end
        do_cmd(4'd1, 32'd8, 1'b0, t);
        n_checks++;
        if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== 32'h200 || ptr_q.size() !== 1 || ptr_q[0] !== 32'h8) begin
            n_fail++; $display("FAIL rst_q1_ptr: addr %h want 200 ptr %h want 8", (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hX,
                               (ptr_q.size() > 0) ? ptr_q[0] : 32'hX);
        end
        do_cmd(4'd2, 32'd8, 1'b0, t);
        n_checks++;
        if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== 32'h400) begin
            n_fail++; $display("FAIL rst_q2_ptr: addr %h want 400", (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hX);
        end
        do_cmd(4'd3, 32'd8, 1'b0, t);
        n_checks++;
        if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== 32'h600) begin
            n_fail++; $display("FAIL rst_q3_ptr: addr %h want 600", (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hX);
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_multi_burst();
        test_wrap();
        test_zero_bytes();
        test_bad_queue();
        test_backpressure();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_ddr_queue_engine.md
# rd_ddr_queue_engine

Responder end of the DDR read-request handshake. It accepts one queue read command at a time (queue index plus byte count) from the read port controller and splits it into AXI4 read bursts. Bursts run from a per-queue read pointer inside that queue's DDR ring region. The engine streams the returned data downstream, advances and publishes the queue's read pointer, and pulses `o_rd_queue_finish` when the command is fully drained.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address and byte-count width
- C_M_AXI_DATA_WIDTH, 64, AXI data width; beat size BB = C_M_AXI_DATA_WIDTH/8 bytes
- P_DDR_LOCAL_QUEUE, 4, width of the queue index field
- P_QUEUE_NUM, 8, number of ring queues
- P_QUEUE_SIZE, 32'h0008_0000, bytes per queue region; multiple of BB
- P_BASE_ADDR, 32'h0000_0000, DDR base of queue 0; queue q base = P_BASE_ADDR + q*P_QUEUE_SIZE
- P_BURST_LEN, 16, maximum beats per AR burst

Ports:
- i_clk, in, 1, sole clock
- i_rst, in, 1, reset: synchronous, active-low
- i_rd_flag, in, 1, tag for the command; copied to o_data_flag
- i_rd_queue, in, P_DDR_LOCAL_QUEUE, queue index
- i_rd_byte, in, C_M_AXI_ADDR_WIDTH, bytes to read
- i_rd_byte_valid, in, 1, command valid
- o_rd_byte_ready, out, 1, command ready
- o_rd_queue_finish, out, 1, one-cycle pulse when the command completes
- o_rd_err, out, 1, one-cycle pulse when a command has an illegal queue index
- o_m_axi_araddr, out, C_M_AXI_ADDR_WIDTH, burst address
- o_m_axi_arlen, out, 8, beats-1
- o_m_axi_arvalid, out, 1; i_m_axi_arready, in, 1
- i_m_axi_rdata, in, C_M_AXI_DATA_WIDTH; i_m_axi_rvalid, in, 1; i_m_axi_rlast, in, 1; o_m_axi_rready, out, 1
- o_data, out, C_M_AXI_DATA_WIDTH; o_data_keep, out, BB; o_data_valid, o_data_last, o_data_flag, out, 1 each; i_data_ready, in, 1
- o_rd_ptr_valid, out, 1; o_rd_ptr_queue, out, P_DDR_LOCAL_QUEUE; o_rd_ptr, out, C_M_AXI_ADDR_WIDTH, new queue-relative read offset

## Operation
- Per-queue offset registers rptr[q], range 0..P_QUEUE_SIZE-BB, always BB-aligned. Reset value 0.
- States and transitions:
  - IDLE: o_rd_byte_ready=1. On valid&ready, latch queue/bytes/flag and go to CALC.
  - CALC: total beats = ceil(bytes/BB). Zero bytes → DONE. Queue ≥ P_QUEUE_NUM → DONE with o_rd_err.
  - CALC (per burst): beats = min(remaining beats, P_BURST_LEN, (P_QUEUE_SIZE-rptr)/BB), then go to AR.
  - AR: o_m_axi_arvalid=1, araddr = base(q)+rptr[q], arlen = beats-1. Hold until arready, then go to DATA.
  - DATA: o_m_axi_rready = i_data_ready; o_data_valid = i_m_axi_rvalid; o_data = rdata. Each handshake decrements remaining beats and advances rptr by BB, wrapping to 0 at P_QUEUE_SIZE. On rlast: remaining>0 → CALC, else DONE.
  - DONE: pulse o_rd_queue_finish. Pulse o_rd_ptr_valid with the final rptr (not for err/zero-byte). Return to IDLE.
- Only one burst is outstanding at a time; AR is never issued before the previous rlast.
- o_data_last=1 on the final beat of the command only. o_data_keep is all-ones except on the last beat, where the low (bytes mod BB) bits are set (all ones if 0).
- Each burst must end with rlast exactly at its issued beat count. A mismatch is a bench error and is not recovered.

## Timing
- Reset (i_rst=0 at a clock edge): all outputs 0, state IDLE, all rptr 0. Any in-flight burst is abandoned; AXI traffic after reset is the bench's concern.
- o_rd_byte_ready is 1 in the first cycle after reset release.
- Command accepted at cycle T: CALC at T+1, arvalid at T+2.
- Each burst after the first: arvalid 2 cycles after the previous rlast handshake (DATA→CALC→AR).
- o_rd_queue_finish, o_rd_ptr_valid: the cycle after the final R handshake. Zero-byte or err commands: T+2.
- New command accepted no earlier than the cycle after the finish pulse.
- o_data_* is combinational from R; backpressure via i_data_ready is honoured beat-exact.

## Test plan
- Queue 2, 300 bytes, rptr[2]=0, no backpressure → araddr 0x0010_0000/0x0010_0080/0x0010_0100, arlen 15/15/5. 38 beats; last beat keep 0x0F with o_data_last. Finish pulse; o_rd_ptr=0x130.
- Queue 0 at rptr=0x7FFC0, 128 bytes → bursts at 0x7FFC0 (arlen 7) and 0x0 (arlen 7). o_rd_ptr=0x40.
- i_rd_byte=0 → no arvalid; finish at T+2; no o_rd_ptr_valid.
- i_rd_queue=9 → o_rd_err and finish at T+2; no AXI activity; all rptr unchanged.
- Random i_data_ready and rvalid gaps on 1000 bytes → 125 beats delivered in order, none dropped or duplicated. arready held low 5 cycles → araddr/arlen stable throughout.
- i_rst=0 mid-DATA → next cycle all outputs 0, ready=1 after release, rptr all 0.
